// File: rtl/iddr_deser.sv
// rtl/iddr_deser.sv - IDDR Q1/Q2 deserializer with bit-slip and optional training alignment
// Purpose: collects one rising-edge (Q1) and one falling-edge (Q2) bit per enabled
//   C cycle and assembles them into WIDTH-bit words. A programmable bit-slip offset
//   selects the word window from a 2*WIDTH-bit history.
// Optional feature macro: AUTO_ALIGN_EN (training-pattern alignment FSM).
// Ports:
//   C          clock (same as IDDR C)
//   R_N        asynchronous active-low reset
//   CE         capture enable; 0 freezes capture state
//   Q1, Q2     IDDR rising / falling samples (Q1 is earlier in time)
//   BITSLIP    pulse: advance slip offset by one bit
//   ALIGN_REQ  pulse: start auto-alignment
//   DOUT       assembled word, MSB oldest
//   VALID      one-cycle strobe, DOUT is new
//   SLIP       current bit-slip offset
//   ALIGNED    training lock achieved
//   ALIGN_FAIL training exhausted all offsets
module iddr_deser #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(8'hA5),
  parameter int MATCH_CNT = 4,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             C,
  input  logic             R_N,
  input  logic             CE,
  input  logic             Q1,
  input  logic             Q2,
  input  logic             BITSLIP,
  input  logic             ALIGN_REQ,
  output logic [WIDTH-1:0] DOUT,
  output logic             VALID,
  output logic [SW-1:0]    SLIP,
  output logic             ALIGNED,
  output logic             ALIGN_FAIL
);

  localparam int PW = $clog2(WIDTH / 2);
  localparam logic [PW-1:0] PH_LAST = PW'(WIDTH / 2 - 1);

  logic [2*WIDTH-1:0] hist;
  logic [PW-1:0]      ph;
  logic               pend;     // a word completed on the previous enabled edge
  logic               emit;
  logic [WIDTH-1:0]   word;
  logic [SW-1:0]      slip_inc;

  // Emission waits for an enabled edge so a frozen interface never strobes.
  assign emit     = CE & pend;
  assign word     = WIDTH'(hist >> SLIP);
  assign slip_inc = (SLIP == SW'(WIDTH - 1)) ? '0 : SLIP + SW'(1);

  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) begin
      hist  <= '0;
      ph    <= '0;
      pend  <= 1'b0;
      DOUT  <= '0;
      VALID <= 1'b0;
    end else begin
      VALID <= emit;
      if (emit) DOUT <= word;
      if (CE) begin
        hist <= {hist[2*WIDTH-3:0], Q1, Q2};
        pend <= (ph == PH_LAST);
        ph   <= (ph == PH_LAST) ? '0 : ph + PW'(1);
      end
    end
  end

`ifdef AUTO_ALIGN_EN
  localparam int TW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_CONFIRM, S_LOCKED, S_FAIL} state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   tries, tries_nx;
  logic [3:0]      matches, matches_nx;
  logic [SW-1:0]   slip_nx;
  logic            hit;

  assign hit        = (word == TRAIN_PATTERN);
  assign ALIGNED    = (state == S_LOCKED);
  assign ALIGN_FAIL = (state == S_FAIL);

  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) begin
      state   <= S_IDLE;
      tries   <= '0;
      matches <= '0;
      SLIP    <= '0;
    end else begin
      state   <= state_nx;
      tries   <= tries_nx;
      matches <= matches_nx;
      SLIP    <= slip_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    tries_nx   = tries;
    matches_nx = matches;
    slip_nx    = SLIP;
    if (ALIGN_REQ) begin
      // Same action from every state: (re)start the search, keep SLIP.
      state_nx   = S_SEARCH;
      tries_nx   = '0;
      matches_nx = '0;
    end else begin
      case (state)
        S_SEARCH, S_CONFIRM: begin
          if (emit) begin
            if (hit) begin
              matches_nx = (state == S_SEARCH) ? 4'd1 : matches + 4'd1;
              state_nx   = (matches_nx == 4'(MATCH_CNT)) ? S_LOCKED : S_CONFIRM;
            end else begin
              matches_nx = '0;
              if (tries == TW'(WIDTH - 1)) begin
                // Last offset tried: SLIP stays on it.
                state_nx = S_FAIL;
                tries_nx = TW'(WIDTH);
              end else begin
                state_nx = S_SEARCH;
                tries_nx = tries + TW'(1);
                slip_nx  = slip_inc;
              end
            end
          end
        end
        default: begin
          if (BITSLIP) slip_nx = slip_inc;
        end
      endcase
    end
  end
`else
  logic unused_align;

  assign ALIGNED      = 1'b0;
  assign ALIGN_FAIL   = 1'b0;
  assign unused_align = ALIGN_REQ ^ (^TRAIN_PATTERN) ^ (MATCH_CNT != 0);

  always_ff @(posedge C or negedge R_N) begin
    if (!R_N)         SLIP <= '0;
    else if (BITSLIP) SLIP <= slip_inc;
  end
`endif

endmodule

// File: tb/tb_iddr_deser.sv
// tb/tb_iddr_deser.sv - self-checking bench for iddr_deser against a bit-stream reference model
module tb_iddr_deser;
  localparam int W = 8;
  localparam logic [7:0] PAT = 8'hA5;
  localparam int MC = 4;
`ifdef AUTO_ALIGN_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic C = 1'b0, R_N = 1'b1, CE = 1'b0, Q1 = 1'b0, Q2 = 1'b0, BITSLIP = 1'b0, ALIGN_REQ = 1'b0;
  logic [7:0] DOUT;
  logic       VALID;
  logic [2:0] SLIP;
  logic       ALIGNED, ALIGN_FAIL;

  int checks = 0;
  int failures = 0;

  iddr_deser #(.WIDTH(W), .TRAIN_PATTERN(PAT), .MATCH_CNT(MC)) dut (
    .C(C), .R_N(R_N), .CE(CE), .Q1(Q1), .Q2(Q2), .BITSLIP(BITSLIP), .ALIGN_REQ(ALIGN_REQ),
    .DOUT(DOUT), .VALID(VALID), .SLIP(SLIP), .ALIGNED(ALIGNED), .ALIGN_FAIL(ALIGN_FAIL)
  );

  always #5 C = ~C;

  // Reference model: every captured bit in arrival order, plus alignment bookkeeping.
  logic bits[$];
  int   pairs;
  bit   pend_m;
  int   mslip;
  bit   m_search, m_locked, m_fail;
  int   m_tries, m_match;
  logic       exp_v;
  logic [7:0] exp_d;

  // Word with offset s: bit i is the bit that arrived s+i bits before the newest one.
  function automatic logic [7:0] ref_word(int s);
    logic [7:0] w;
    int n;
    n = bits.size();
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = n - 1 - s - i;
      w[i] = (idx >= 0) ? bits[idx] : 1'b0;
    end
    return w;
  endfunction

  // Bit k of a repeating PAT stream shifted by off bits.
  function automatic logic pb(int k, int off);
    logic [7:0] p;
    p = PAT;
    return p[7 - ((k + off) % 8)];
  endfunction

  task automatic model_reset;
    bits.delete();
    pairs = 0; pend_m = 0; mslip = 0;
    m_search = 0; m_locked = 0; m_fail = 0; m_tries = 0; m_match = 0;
    exp_v = 1'b0; exp_d = 8'h00;
  endtask

  task automatic do_reset;
    CE = 0; Q1 = 0; Q2 = 0; BITSLIP = 0; ALIGN_REQ = 0;
    R_N = 1'b0;
    repeat (2) @(posedge C);
    @(negedge C);
    R_N = 1'b1;
    model_reset();
  endtask

  // Drives one clock cycle and advances the model; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic ce, input logic q1, input logic q2, input logic bs, input logic ar);
    CE = ce; Q1 = q1; Q2 = q2; BITSLIP = bs; ALIGN_REQ = ar;
    exp_v = ce && pend_m;
    if (exp_v) exp_d = ref_word(mslip);
    @(posedge C);
    #1;
    BITSLIP = 1'b0; ALIGN_REQ = 1'b0;
    if (ce) begin
      bits.push_back(q1);
      bits.push_back(q2);
      pend_m = ((pairs % (W / 2)) == (W / 2 - 1));
      pairs++;
    end
    if (AUTO && ar) begin
      m_search = 1; m_locked = 0; m_fail = 0; m_tries = 0; m_match = 0;
    end else if (m_search) begin
      if (exp_v) begin
        if (exp_d == PAT) begin
          m_match++;
          if (m_match == MC) begin m_search = 0; m_locked = 1; end
        end else begin
          m_match = 0;
          m_tries++;
          if (m_tries == W) begin m_search = 0; m_fail = 1; end
          else mslip = (mslip + 1) % W;
        end
      end
    end else if (bs) begin
      mslip = (mslip + 1) % W;
    end
  endtask

  task automatic send_pat(input int n, input int off);
    for (int i = 0; i < n; i++) begin
      int k;
      k = bits.size();
      cycle(1'b1, pb(k, off), pb(k + 1, off), 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset;
    #3;
    R_N = 1'b0;
    #1;
    checks++; if (DOUT !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", DOUT); end
    checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", VALID); end
    checks++; if (SLIP !== 3'd0) begin failures++; $display("FAIL reset_slip got=%0d exp=0", SLIP); end
    checks++; if (ALIGNED !== 1'b0) begin failures++; $display("FAIL reset_aligned got=%b exp=0", ALIGNED); end
    checks++; if (ALIGN_FAIL !== 1'b0) begin failures++; $display("FAIL reset_align_fail got=%b exp=0", ALIGN_FAIL); end
    do_reset();
  endtask

  task automatic test_stream;
    int nv;
    nv = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      int k;
      k = bits.size();
      cycle(1'b1, pb(k, 0), pb(k + 1, 0), 1'b0, 1'b0);
      checks++; if (VALID !== exp_v) begin failures++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, VALID, exp_v); end
      if (VALID === 1'b1) begin
        nv++;
        checks++; if (DOUT !== 8'hA5) begin failures++; $display("FAIL stream_dout cyc=%0d got=%h exp=a5", i, DOUT); end
      end
    end
    checks++; if (nv != 2) begin failures++; $display("FAIL stream_count got=%0d exp=2", nv); end
  endtask

  // Continues the stream from test_stream: the first cycle here emits a word.
  task automatic test_bitslip;
    int nv;
    logic [7:0] w0, w1;
    nv = 0; w0 = 8'h00; w1 = 8'h00;
    for (int i = 0; i < 9; i++) begin
      int k;
      k = bits.size();
      cycle(1'b1, pb(k, 0), pb(k + 1, 0), (i == 0), 1'b0);
      if (VALID === 1'b1) begin
        if (nv == 0) w0 = DOUT;
        if (nv == 1) w1 = DOUT;
        nv++;
      end
    end
    checks++; if (SLIP !== 3'd1) begin failures++; $display("FAIL slip_one got=%0d exp=1", SLIP); end
    checks++; if (w0 !== 8'hA5) begin failures++; $display("FAIL slip_same_cycle_word got=%h exp=a5", w0); end
    checks++; if (w1 !== 8'hD2) begin failures++; $display("FAIL slip_next_word got=%h exp=d2", w1); end
    for (int i = 0; i < 15; i++) begin
      int k;
      k = bits.size();
      cycle(1'b1, pb(k, 0), pb(k + 1, 0), (i < 7), 1'b0);
      checks++; if (SLIP !== 3'(mslip)) begin failures++; $display("FAIL slip_step cyc=%0d got=%0d exp=%0d", i, SLIP, mslip); end
      if (VALID === 1'b1) begin
        checks++; if (DOUT !== exp_d) begin failures++; $display("FAIL slip_dout cyc=%0d got=%h exp=%h", i, DOUT, exp_d); end
      end
    end
    checks++; if (SLIP !== 3'd0) begin failures++; $display("FAIL slip_wrap got=%0d exp=0", SLIP); end
    checks++; if (DOUT !== 8'hA5) begin failures++; $display("FAIL slip_wrap_dout got=%h exp=a5", DOUT); end
  endtask

  task automatic test_ce_hold;
    do_reset();
    send_pat(2, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL ce_hold_valid cyc=%0d got=%b exp=0", i, VALID); end
    end
    for (int i = 0; i < 2; i++) begin
      int k;
      k = bits.size();
      cycle(1'b1, pb(k, 0), pb(k + 1, 0), 1'b0, 1'b0);
      checks++; if (VALID !== 1'b0) begin failures++; $display("FAIL ce_resume_valid cyc=%0d got=%b exp=0", i, VALID); end
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (VALID !== 1'b1) begin failures++; $display("FAIL ce_word_valid got=%b exp=1", VALID); end
    checks++; if (DOUT !== 8'hA5) begin failures++; $display("FAIL ce_word_dout got=%h exp=a5", DOUT); end
  endtask

  task automatic test_random;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic ce, bs;
      ce = ($urandom_range(0, 3) != 0);
      bs = ($urandom_range(0, 15) == 0);
      cycle(ce, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bs, 1'b0);
      checks++; if (VALID !== exp_v) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, VALID, exp_v); end
      checks++; if (DOUT !== exp_d) begin failures++; $display("FAIL rand_dout cyc=%0d got=%h exp=%h", i, DOUT, exp_d); end
      checks++; if (SLIP !== 3'(mslip)) begin failures++; $display("FAIL rand_slip cyc=%0d got=%0d exp=%0d", i, SLIP, mslip); end
    end
  endtask

`ifdef AUTO_ALIGN_EN
  task automatic test_align;
    int nw;
    bit done;
    nw = 0; done = 0;
    do_reset();
    send_pat(10, 3);
    cycle(1'b1, pb(bits.size(), 3), pb(bits.size() + 1, 3), 1'b0, 1'b1);
    for (int i = 0; i < 80 && !done; i++) begin
      int k;
      k = bits.size();
      cycle(1'b1, pb(k, 3), pb(k + 1, 3), 1'b0, 1'b0);
      if (VALID === 1'b1) nw++;
      checks++; if (SLIP !== 3'(mslip)) begin failures++; $display("FAIL align_slip cyc=%0d got=%0d exp=%0d", i, SLIP, mslip); end
      if (ALIGNED === 1'b1) done = 1;
    end
    checks++; if (!done) begin failures++; $display("FAIL align_timeout got=unlocked exp=locked"); end
    checks++; if (nw != 7) begin failures++; $display("FAIL align_words got=%0d exp=7", nw); end
    checks++; if (SLIP !== 3'd3) begin failures++; $display("FAIL align_final_slip got=%0d exp=3", SLIP); end
    checks++; if (ALIGN_FAIL !== 1'b0) begin failures++; $display("FAIL align_fail_flag got=%b exp=0", ALIGN_FAIL); end
  endtask

  task automatic test_align_fail;
    int nw;
    bit done;
    nw = 0; done = 0;
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 80 && !done; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (VALID === 1'b1) nw++;
      if (ALIGN_FAIL === 1'b1) done = 1;
    end
    checks++; if (!done) begin failures++; $display("FAIL fail_timeout got=no_fail exp=fail"); end
    checks++; if (nw != 8) begin failures++; $display("FAIL fail_words got=%0d exp=8", nw); end
    checks++; if (ALIGNED !== 1'b0) begin failures++; $display("FAIL fail_aligned got=%b exp=0", ALIGNED); end
    checks++; if (SLIP !== 3'(mslip)) begin failures++; $display("FAIL fail_slip got=%0d exp=%0d", SLIP, mslip); end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (ALIGN_FAIL !== 1'b0) begin failures++; $display("FAIL refail_clear got=%b exp=0", ALIGN_FAIL); end
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (SLIP !== 3'(mslip)) begin failures++; $display("FAIL research_slip got=%0d exp=%0d", SLIP, mslip); end
  endtask

  task automatic test_reset_confirm;
    bit done;
    int cnt;
    done = 0; cnt = 0;
    do_reset();
    send_pat(10, 3);
    cycle(1'b1, pb(bits.size(), 3), pb(bits.size() + 1, 3), 1'b0, 1'b1);
    for (int i = 0; i < 60 && !done; i++) begin
      int k;
      k = bits.size();
      cycle(1'b1, pb(k, 3), pb(k + 1, 3), 1'b0, 1'b0);
      if (VALID === 1'b1 && DOUT === 8'hA5) done = 1;
    end
    checks++; if (!done) begin failures++; $display("FAIL confirm_timeout got=no_match exp=match"); end
    #2;
    R_N = 1'b0;
    #1;
    checks++; if (DOUT !== 8'h00) begin failures++; $display("FAIL rst_cfm_dout got=%h exp=00", DOUT); end
    checks++; if (SLIP !== 3'd0) begin failures++; $display("FAIL rst_cfm_slip got=%0d exp=0", SLIP); end
    checks++; if (VALID !== 1'b0 || ALIGNED !== 1'b0 || ALIGN_FAIL !== 1'b0) begin failures++; $display("FAIL rst_cfm_flags got=%b%b%b exp=000", VALID, ALIGNED, ALIGN_FAIL); end
    @(negedge C);
    R_N = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (VALID === 1'b1) cnt = i + 1;
    end
    checks++; if (cnt != 5) begin failures++; $display("FAIL rst_cfm_first_valid got=%0d exp=5", cnt); end
    checks++; if (ALIGNED !== 1'b0) begin failures++; $display("FAIL rst_cfm_idle got=%b exp=0", ALIGNED); end
  endtask
`else
  task automatic test_align_off;
    do_reset();
    send_pat(10, 3);
    cycle(1'b1, pb(bits.size(), 3), pb(bits.size() + 1, 3), 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      int k;
      k = bits.size();
      cycle(1'b1, pb(k, 3), pb(k + 1, 3), (i == 5), 1'b0);
      checks++; if (ALIGNED !== 1'b0 || ALIGN_FAIL !== 1'b0) begin failures++; $display("FAIL off_flags cyc=%0d got=%b%b exp=00", i, ALIGNED, ALIGN_FAIL); end
      checks++; if (SLIP !== 3'(mslip)) begin failures++; $display("FAIL off_slip cyc=%0d got=%0d exp=%0d", i, SLIP, mslip); end
      if (VALID === 1'b1) begin
        checks++; if (DOUT !== exp_d) begin failures++; $display("FAIL off_dout cyc=%0d got=%h exp=%h", i, DOUT, exp_d); end
      end
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_bitslip();
    test_ce_hold();
    test_random();
`ifdef AUTO_ALIGN_EN
    test_align();
    test_align_fail();
    test_reset_confirm();
`else
    test_align_off();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
